// File: rtl/pipe_stage_buf.sv
// Ready/valid pipeline stage register with a 2-entry skid buffer (head + skid),
// synchronous flush to bubbles, and saturating stall/squash counters.
module pipe_stage_buf #(
    parameter int CTRL_W = 9,
    parameter int DATA_W = 121,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  squash_cnt
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
    // in_ready/out_valid are pure functions of the registered occupancy.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CTRL_W-1:0]  head_ctrl_q, head_ctrl_d, skid_ctrl_q, skid_ctrl_d;
    logic [DATA_W-1:0]  head_data_q, head_data_d, skid_data_q, skid_data_d;
    logic [CNT_W-1:0]   stall_q, stall_d, squash_q, squash_d;
    logic               acc, emit, stall_inc;
    logic [1:0]         squash_add;
    logic [CNT_W:0]     squash_sum;

    assign in_ready   = (state_q != FULL);
    assign out_valid  = (state_q != EMPTY);
    assign out_ctrl   = head_ctrl_q;
    assign out_data   = head_data_q;
    assign occupancy  = state_q;
    assign stall_cnt  = stall_q;
    assign squash_cnt = squash_q;

    assign acc       = in_valid & in_ready & ~flush;
    assign emit      = out_valid & out_ready;
    assign stall_inc = in_valid & ~in_ready & ~flush;

    always_comb begin
        state_d     = state_q;
        head_ctrl_d = head_ctrl_q;
        head_data_d = head_data_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_data_d = skid_data_q;
        if (flush) begin
            state_d     = EMPTY;
            head_ctrl_d = '0;
            head_data_d = '0;
            skid_ctrl_d = '0;
            skid_data_d = '0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (acc) begin
                        state_d     = ONE;
                        head_ctrl_d = in_ctrl;
                        head_data_d = in_data;
                    end
                end
                ONE: begin
                    if (acc && emit) begin
                        head_ctrl_d = in_ctrl;
                        head_data_d = in_data;
                    end else if (acc) begin
                        state_d     = FULL;
                        skid_ctrl_d = in_ctrl;
                        skid_data_d = in_data;
                    end else if (emit) begin
                        // Drained head must read back as a bubble.
                        state_d     = EMPTY;
                        head_ctrl_d = '0;
                        head_data_d = '0;
                    end
                end
                FULL: begin
                    if (emit) begin
                        state_d     = ONE;
                        head_ctrl_d = skid_ctrl_q;
                        head_data_d = skid_data_q;
                        skid_ctrl_d = '0;
                        skid_data_d = '0;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

    // Entries lost to a flush: everything held minus the one leaving downstream.
    always_comb begin
        squash_add = flush ? (occupancy - {1'b0, emit}) : 2'd0;
        squash_sum = {1'b0, squash_q} + {{(CNT_W-1){1'b0}}, squash_add};
        squash_d   = squash_sum[CNT_W] ? {CNT_W{1'b1}} : squash_sum[CNT_W-1:0];
        stall_d    = stall_q;
        if (stall_inc && (stall_q != {CNT_W{1'b1}})) begin
            stall_d = stall_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= EMPTY;
            head_ctrl_q <= '0;
            head_data_q <= '0;
            skid_ctrl_q <= '0;
            skid_data_q <= '0;
            stall_q     <= '0;
            squash_q    <= '0;
        end else begin
            state_q     <= state_d;
            head_ctrl_q <= head_ctrl_d;
            head_data_q <= head_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            skid_data_q <= skid_data_d;
            stall_q     <= stall_d;
            squash_q    <= squash_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: queue-based reference model, randomized and directed stimulus,
// an emit monitor that pops the expected queue, and counter checks on two counter widths.
module tb_pipe_stage_buf;

    localparam int CTRL_W = 9;
    localparam int DATA_W = 121;
    localparam int W      = CTRL_W + DATA_W;

    logic              clk;
    logic              rst;
    logic              flush;
    logic              in_valid;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic              out_ready;

    logic              in_ready, out_valid;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        occupancy;
    logic [15:0]       stall_cnt, squash_cnt;

    logic              s_in_ready, s_out_valid;
    logic [CTRL_W-1:0] s_out_ctrl;
    logic [DATA_W-1:0] s_out_data;
    logic [1:0]        s_occupancy;
    logic [3:0]        s_stall_cnt, s_squash_cnt;

    pipe_stage_buf #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
        .occupancy(occupancy), .stall_cnt(stall_cnt), .squash_cnt(squash_cnt)
    );

    pipe_stage_buf #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(s_in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_ctrl(s_out_ctrl), .out_data(s_out_data),
        .occupancy(s_occupancy), .stall_cnt(s_stall_cnt), .squash_cnt(s_squash_cnt)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard state: exp_q holds exactly the entries the stage should be holding.
    logic [W-1:0] exp_q[$];
    int  checks      = 0;
    int  failures    = 0;
    int  stall_m     = 0;
    int  squash_m    = 0;
    bit  pend_clear  = 0;
    int  emitted     = 0;

    function automatic int sat(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_state(input int n);
        chk("occupancy", W'(occupancy), W'(n));
        chk("in_ready", W'(in_ready), W'(n < 2));
        chk("out_valid", W'(out_valid), W'(n > 0));
        chk("stall_cnt", W'(stall_cnt), W'(sat(stall_m, 65535)));
        chk("squash_cnt", W'(squash_cnt), W'(sat(squash_m, 65535)));
        chk("sat_stall_cnt", W'(s_stall_cnt), W'(sat(stall_m, 15)));
        chk("sat_squash_cnt", W'(s_squash_cnt), W'(sat(squash_m, 15)));
        chk("sat_occupancy", W'(s_occupancy), W'(n));
        if (n == 0) begin
            chk("bubble", {out_ctrl, out_data}, '0);
        end
    endtask

    // Driver: one cycle of stimulus, model updated from the stage's rules.
    task automatic step(input logic iv, input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d,
                        input logic ordy, input logic fl);
        int  n;
        bit  em;
        @(negedge clk);
        if (pend_clear) begin
            exp_q.delete();
            pend_clear = 0;
        end
        n = exp_q.size();
        chk_state(n);
        in_valid  = iv;
        in_ctrl   = c;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        em = (n > 0) && ordy;
        if (fl) begin
            squash_m += n - int'(em);
            pend_clear = 1;
        end else if (iv && n < 2) begin
            exp_q.push_back({c, d});
        end
        if (iv && n == 2 && !fl) stall_m++;
    endtask

    function automatic logic [DATA_W-1:0] rnd_data();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Monitor: just before each rising edge, an emit pops and checks the queue head.
    initial begin
        forever begin
            @(negedge clk);
            #4;
            if (rst && out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL emit_unexpected: got %0h expected no entry", {out_ctrl, out_data});
                end else begin
                    logic [W-1:0] e;
                    e = exp_q.pop_front();
                    emitted++;
                    if ({out_ctrl, out_data} !== e) begin
                        failures++;
                        $display("FAIL emit_data: got %0h expected %0h at %0t", {out_ctrl, out_data}, e, $time);
                    end
                end
                chk("sat_emit", {s_out_ctrl, s_out_data}, {out_ctrl, out_data});
            end
        end
    end

    task automatic reset_phase(input int cycles);
        @(negedge clk);
        #2;
        rst = 1'b0;
        exp_q.delete();
        pend_clear = 0;
        stall_m  = 0;
        squash_m = 0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            chk_state(0);
            in_valid  = 1'b1;
            flush     = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            in_ctrl   = CTRL_W'($urandom);
            in_data   = rnd_data();
        end
        @(negedge clk);
        chk_state(0);
        rst      = 1'b1;
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    initial begin
        int st_before;
        int sq_before;
        rst = 1'b0;
        flush = 1'b0;
        in_valid = 1'b0;
        in_ctrl = '0;
        in_data = '0;
        out_ready = 1'b0;

        reset_phase(3);

        // Streaming: 1..8 back to back
        for (int i = 1; i <= 8; i++) step(1'b1, CTRL_W'(i), DATA_W'(i), 1'b1, 1'b0);
        step(1'b0, '0, '0, 1'b1, 1'b0);
        step(1'b0, '0, '0, 1'b1, 1'b0);
        chk("stream_emitted", W'(emitted), W'(8));

        // Backpressure: A, B accepted, C waits upstream
        step(1'b1, 9'h0A1, DATA_W'(32'hA), 1'b0, 1'b0);
        step(1'b1, 9'h0B2, DATA_W'(32'hB), 1'b0, 1'b0);
        st_before = stall_m;
        repeat (4) step(1'b1, 9'h0C3, DATA_W'(32'hC), 1'b0, 1'b0);
        chk("bp_stall_model", W'(stall_m - st_before), W'(4));
        step(1'b1, 9'h0C3, DATA_W'(32'hC), 1'b1, 1'b0);
        step(1'b1, 9'h0C3, DATA_W'(32'hC), 1'b1, 1'b0);
        step(1'b0, '0, '0, 1'b1, 1'b0);
        step(1'b0, '0, '0, 1'b1, 1'b0);
        chk("bp_emitted", W'(emitted), W'(11));

        // Flush while FULL, downstream stalled, input offered
        step(1'b1, 9'h011, rnd_data(), 1'b0, 1'b0);
        step(1'b1, 9'h022, rnd_data(), 1'b0, 1'b0);
        sq_before = squash_m;
        step(1'b1, 9'h033, rnd_data(), 1'b0, 1'b1);
        step(1'b0, '0, '0, 1'b0, 1'b0);
        chk("flush_full_squash", W'(squash_m - sq_before), W'(2));

        // Flush in ONE with emit: entry still delivered
        step(1'b1, 9'h155, DATA_W'(32'h55), 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b1, 1'b1);
        step(1'b0, '0, '0, 1'b0, 1'b0);
        chk("flush_one_emitted", W'(emitted), W'(12));

        // Saturation: 20 stall cycles
        step(1'b1, 9'h1, rnd_data(), 1'b0, 1'b0);
        step(1'b1, 9'h2, rnd_data(), 1'b0, 1'b0);
        repeat (20) step(1'b1, 9'h3, rnd_data(), 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b0, 1'b0);

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 9) < 7), CTRL_W'($urandom), rnd_data(),
                 1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 19) == 0));
        end

        // Reset mid-transfer discards held entries uncounted
        step(1'b1, 9'h1AA, rnd_data(), 1'b0, 1'b0);
        step(1'b1, 9'h1BB, rnd_data(), 1'b0, 1'b0);
        reset_phase(2);
        for (int i = 0; i < 100; i++) begin
            step(1'($urandom_range(0, 9) < 6), CTRL_W'($urandom), rnd_data(),
                 1'($urandom_range(0, 9) < 5), 1'($urandom_range(0, 29) == 0));
        end

        // Bounded drain
        for (int i = 0; i < 4; i++) step(1'b0, '0, '0, 1'b1, 1'b0);
        @(negedge clk);
        if (pend_clear) begin
            exp_q.delete();
            pend_clear = 0;
        end
        chk("drain_left", W'(exp_q.size()), W'(0));
        chk_state(0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
